// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional FWFT read port.
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_acc;
    logic             rd_acc;

    // Flags decode straight from the count register so they never lag it.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            if (rd_acc) rptr <= rptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set beats clear when both happen in the same cycle.
            overflow  <= (overflow  && !clr_err) || (wr_en && !wr_acc);
            underflow <= (underflow && !clr_err) || (rd_en && !rd_acc);
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) mem[wptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so reset dout is 0.
            assign dout       = empty ? '0 : mem[rptr];
            assign dout_valid = !empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             dv_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    if (rd_acc) dout_q <= mem[rptr];
                    dv_q <= rd_acc;
                end
            end
            assign dout       = dout_q;
            assign dout_valid = dv_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-read instance checked each cycle
// against a queue model, plus an FWFT instance driven through short sequences.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // standard-mode instance
    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // FWFT instance
    logic       b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic [7:0] b_din = '0;
    logic [7:0] b_dout;
    logic       b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0] b_count;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut_std (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
        .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // reference model for the standard instance
    logic [7:0] q [$];
    logic [7:0] qb [$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_dv = 1'b0;
    logic [7:0] m_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",        32'(count),        32'(q.size()));
        chk("full",         32'(full),         32'(q.size() == 16));
        chk("empty",        32'(empty),        32'(q.size() == 0));
        chk("almost_full",  32'(almost_full),  32'(q.size() >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 4));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
        chk("dout_valid",   32'(dout_valid),   32'(m_dv));
        chk("dout",         32'(dout),         32'(m_dout));
    endtask

    // One clock of the standard instance: drive, predict, step, compare.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic ra, wa;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        ra = r && (q.size() != 0);
        wa = w && ((q.size() != 16) || ra);
        @(posedge clk); #1;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        m_dv  = ra;
        m_ovf = (m_ovf && !c) || (w && !wa);
        m_unf = (m_unf && !c) || (r && !ra);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    task automatic b_step(input logic w, input logic [7:0] d, input logic r);
        b_wr = w; b_din = d; b_rd = r;
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("b_reset_dout",  32'(b_dout),  32'h0);
        chk("b_reset_dv",    32'(b_dv),    32'h0);
        chk("b_reset_empty", 32'(b_empty), 32'h1);
        reset = 1'b1;

        // FWFT: written word shows up the cycle after the write edge, no rd_en
        b_step(1'b1, 8'h3C, 1'b0);
        chk("b_fwft_dout",  32'(b_dout),  32'h3C);
        chk("b_fwft_dv",    32'(b_dv),    32'h1);
        chk("b_fwft_count", 32'(b_count), 32'h1);
        b_step(1'b0, 8'h00, 1'b1);
        chk("b_ack_empty", 32'(b_empty), 32'h1);
        chk("b_ack_dv",    32'(b_dv),    32'h0);
        b_step(1'b0, 8'h00, 1'b1);
        chk("b_underflow", 32'(b_unf), 32'h1);
        for (int i = 0; i < 3; i++) begin
            qb.push_back(8'(8'h11 * (i + 1)));
            b_step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            chk("b_seq_dv", 32'(b_dv), 32'h1);
            chk("b_seq_dout", 32'(b_dout), 32'(qb.pop_front()));
            b_step(1'b0, 8'h00, 1'b1);
        end
        chk("b_drained", 32'(b_empty), 32'h1);

        // fill 0x00..0x0F, flags tracked each step by the model
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_full_set", 32'(overflow), 32'h1);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw_dout",  32'(dout),  32'h00);
        chk("full_rw_count", 32'(count), 32'd16);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'h0);

        // drain: 0x01..0x0F then 0xAA
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("unf_set",   32'(underflow),  32'h1);
        chk("unf_dv",    32'(dout_valid), 32'h0);
        chk("unf_count", 32'(count),      32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_word", 32'(dout), 32'h55);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // streaming across pointer wrap with constant occupancy
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // set beats clear, then leave 7 entries with overflow pending
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(overflow), 32'h1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd7);

        // asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_dout = '0;
        check_all();
        chk("b_async_empty", 32'(b_empty), 32'h1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
